msg_frame_scheduler: RTL and testbench

- Parametrised successor to the fixed 25-channel message transmitter.
- On each frame-start pulse, visits every enabled sensor channel in ascending order and drains a fixed number of beats from that channel's cache FIFO.
- Packs the bytes into OUT_W-bit words and emits a framed stream (header, per-channel headers, data, XOR checksum trailer) toward the SRIO upstream FIFO.
- Adds a runtime channel mask, underrun zero-fill with sticky flags, and prog_full back-pressure.

---
 rtl/msg_frame_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_msg_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_scheduler.sv
// msg_frame_scheduler
// Frame builder for the SRIO upstream path. On each accepted frame-start pulse
// it visits every enabled sensor channel in ascending order, drains a fixed
// number of beats from that channel's cache FIFO, and packs the bytes into
// OUT_W-bit words. Each frame is emitted as a header, then per-channel headers
// with their data, then an XOR checksum trailer. Channels that run dry are
// zero-filled and flagged.
module msg_frame_scheduler #(
   parameter int          CH_NUM       = 25,
   parameter int          DIN_W        = 8,
   parameter int          OUT_W        = 32,
   parameter int          BEATS_PER_CH = 100,
   parameter logic [15:0] SYNC_WORD    = 16'hEB90,
   parameter logic [7:0]  CH_TAG       = 8'hC5
) (
   input  logic                      sys_clk_100m,
   input  logic                      sw_srst_n,
   input  logic                      frame_start_pulse_i,
   input  logic [CH_NUM-1:0]         ch_mask_i,
   output logic [CH_NUM-1:0]         rd_en_o,
   input  logic [CH_NUM*DIN_W-1:0]   din_i,
   input  logic [CH_NUM-1:0]         empty_i,
   output logic                      us_wr_en_o,
   output logic [OUT_W-1:0]          us_wr_dout_o,
   input  logic                      us_prog_full_i,
   output logic                      busy_o,
   output logic [15:0]               frame_cnt_o,
   output logic [CH_NUM-1:0]         underrun_o,
   output logic                      missed_start_o
);

   localparam int WPB = OUT_W / DIN_W;                         // beats per word
   localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int BCW = $clog2(BEATS_PER_CH + 1);
   localparam int PCW = $clog2(WPB + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_CH_HDR  = 3'd2;
   localparam logic [2:0] S_DATA    = 3'd3;
   localparam logic [2:0] S_NEXT_CH = 3'd4;
   localparam logic [2:0] S_TAIL    = 3'd5;

   logic [2:0]         r_state;
   logic [CH_NUM-1:0]  r_mask;
   logic [CHW-1:0]     r_ch;
   logic               r_arm;
   logic               r_busy;
   logic [15:0]        r_frame_cnt;
   logic [CH_NUM-1:0]  r_underrun;
   logic               r_missed;
   logic               r_wr_en;
   logic [OUT_W-1:0]   r_wr_dout;
   logic [OUT_W-1:0]   r_xsum;
   logic [BCW-1:0]     r_issue_cnt;
   logic               r_beat_v;
   logic               r_beat_real;
   logic [OUT_W-1:0]   r_pack;
   logic [PCW-1:0]     r_pack_cnt;
   logic               r_pend;
   logic [OUT_W-1:0]   r_hold;
   logic               r_tail_sent;

   logic               w_issue;
   logic               w_empty_k;
   logic               w_rd_real;
   logic [CH_NUM-1:0]  w_rd_en;
   logic [DIN_W-1:0]   w_din_k;
   logic [DIN_W-1:0]   w_byte;
   logic [OUT_W-1:0]   w_pack_next;
   logic               w_word_done;
   logic               w_from_hdr;
   logic               w_nxt_found;
   logic [CHW-1:0]     w_nxt_ch;
   logic               w_hit;
   logic [OUT_W-1:0]   w_hdr_word;
   logic [OUT_W-1:0]   w_chh_word;

   // A beat is due only in DATA, while beats remain, with no back-pressure and
   // no completed word waiting; an empty FIFO turns the beat into a zero filler.
   // The read strobe is decoded straight from the live empty flag so that
   // back-to-back reads can never run past the last entry of the FIFO.
   assign w_issue   = (r_state == S_DATA) && (r_issue_cnt != BCW'(BEATS_PER_CH))
                      && !us_prog_full_i && !r_pend;
   assign w_empty_k = empty_i[r_ch];
   assign w_rd_real = w_issue && !w_empty_k;

   // Read data of the active channel; filler beats contribute zeros.
   assign w_din_k     = din_i[int'(r_ch) * DIN_W +: DIN_W];
   assign w_byte      = r_beat_real ? w_din_k : {DIN_W{1'b0}};
   assign w_pack_next = (r_pack << DIN_W) | OUT_W'(w_byte);
   assign w_word_done = r_beat_v && (r_pack_cnt == PCW'(WPB - 1));

   assign w_hdr_word = OUT_W'({SYNC_WORD, r_frame_cnt});
   assign w_chh_word = OUT_W'({CH_TAG, 8'(r_ch), 16'(BEATS_PER_CH)});

   // One-hot read enable for the active channel when a real beat is issued.
   always_comb begin
      w_rd_en = {CH_NUM{1'b0}};
      if (w_rd_real) begin
         w_rd_en[r_ch] = 1'b1;
      end else begin
         w_rd_en = {CH_NUM{1'b0}};
      end
   end

   // Lowest enabled channel above the current one (or from zero out of HDR);
   // a descending scan leaves the lowest match in a single cycle.
   always_comb begin
      w_from_hdr  = (r_state == S_HDR);
      w_nxt_found = 1'b0;
      w_nxt_ch    = {CHW{1'b0}};
      w_hit       = 1'b0;
      for (int j = CH_NUM - 1; j >= 0; j--) begin
         w_hit       = r_mask[j] && (w_from_hdr || (j > int'(r_ch)));
         w_nxt_found = w_nxt_found | w_hit;
         w_nxt_ch    = w_hit ? CHW'(j) : w_nxt_ch;
      end
   end

   // Frame sequencer, beat pipeline, word packer and upstream writer.
   always_ff @(posedge sys_clk_100m or negedge sw_srst_n) begin
      if (!sw_srst_n) begin
         r_state     <= S_IDLE;
         r_mask      <= {CH_NUM{1'b0}};
         r_ch        <= {CHW{1'b0}};
         r_arm       <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_cnt <= 16'h0000;
         r_underrun  <= {CH_NUM{1'b0}};
         r_missed    <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_dout   <= {OUT_W{1'b0}};
         r_xsum      <= {OUT_W{1'b0}};
         r_issue_cnt <= {BCW{1'b0}};
         r_beat_v    <= 1'b0;
         r_beat_real <= 1'b0;
         r_pack      <= {OUT_W{1'b0}};
         r_pack_cnt  <= {PCW{1'b0}};
         r_pend      <= 1'b0;
         r_hold      <= {OUT_W{1'b0}};
         r_tail_sent <= 1'b0;
      end else begin
         // A start pulse on the very first cycle after reset is not honoured.
         r_arm   <= 1'b1;
         r_wr_en <= 1'b0;

         if (frame_start_pulse_i && r_busy) begin
            r_missed <= 1'b1;
         end

         // Issue stage: remember what was issued so its data is packed next cycle.
         r_beat_v    <= w_issue;
         r_beat_real <= w_rd_real;
         if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + BCW'(1);
            if (w_empty_k) begin
               r_underrun[r_ch] <= 1'b1;
            end
         end

         // Capture stage: first beat ends up in the MSBs of the word.
         if (r_beat_v) begin
            if (w_word_done) begin
               r_pack     <= {OUT_W{1'b0}};
               r_pack_cnt <= {PCW{1'b0}};
               if (!us_prog_full_i) begin
                  r_wr_en   <= 1'b1;
                  r_wr_dout <= w_pack_next;
                  r_xsum    <= r_xsum ^ w_pack_next;
               end else begin
                  r_pend <= 1'b1;
                  r_hold <= w_pack_next;
               end
            end else begin
               r_pack     <= w_pack_next;
               r_pack_cnt <= r_pack_cnt + PCW'(1);
            end
         end

         // A word held back by prog_full leaves on the first free cycle.
         if (r_pend && !us_prog_full_i) begin
            r_pend    <= 1'b0;
            r_wr_en   <= 1'b1;
            r_wr_dout <= r_hold;
            r_xsum    <= r_xsum ^ r_hold;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_start_pulse_i && r_arm) begin
                  r_mask      <= ch_mask_i;
                  r_underrun  <= {CH_NUM{1'b0}};
                  r_busy      <= 1'b1;
                  r_xsum      <= {OUT_W{1'b0}};
                  r_ch        <= {CHW{1'b0}};
                  r_tail_sent <= 1'b0;
                  r_state     <= S_HDR;
               end
            end
            S_HDR: begin
               if (!us_prog_full_i) begin
                  r_wr_en   <= 1'b1;
                  r_wr_dout <= w_hdr_word;
                  r_xsum    <= w_hdr_word;
                  if (w_nxt_found) begin
                     r_ch    <= w_nxt_ch;
                     r_state <= S_CH_HDR;
                  end else begin
                     r_state <= S_TAIL;
                  end
               end
            end
            S_CH_HDR: begin
               if (!us_prog_full_i) begin
                  r_wr_en     <= 1'b1;
                  r_wr_dout   <= w_chh_word;
                  r_xsum      <= r_xsum ^ w_chh_word;
                  r_issue_cnt <= {BCW{1'b0}};
                  r_state     <= S_DATA;
               end
            end
            S_DATA: begin
               // Leave only once every beat is issued, captured and written.
               if ((r_issue_cnt == BCW'(BEATS_PER_CH)) && !r_beat_v
                   && (r_pack_cnt == {PCW{1'b0}}) && !r_pend) begin
                  r_state <= S_NEXT_CH;
               end
            end
            S_NEXT_CH: begin
               if (w_nxt_found) begin
                  r_ch    <= w_nxt_ch;
                  r_state <= S_CH_HDR;
               end else begin
                  r_state <= S_TAIL;
               end
            end
            S_TAIL: begin
               if (!r_tail_sent) begin
                  if (!us_prog_full_i) begin
                     r_wr_en     <= 1'b1;
                     r_wr_dout   <= r_xsum;
                     r_tail_sent <= 1'b1;
                  end
               end else begin
                  r_busy      <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_en_o        = w_rd_en;
   assign us_wr_en_o     = r_wr_en;
   assign us_wr_dout_o   = r_wr_dout;
   assign busy_o         = r_busy;
   assign frame_cnt_o    = r_frame_cnt;
   assign underrun_o     = r_underrun;
   assign missed_start_o = r_missed;

endmodule

// File: tb/tb_msg_frame_scheduler.sv
// Directed testbench for msg_frame_scheduler with 3 channels of 8 beats each.
// Cache FIFOs are modelled by the bench; expected frames come from a bench-side
// byte model plus hand-computed constants.
module tb_msg_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mask = 3'b000;
   logic [2:0]  rd_en_o;
   logic [23:0] din;
   logic [2:0]  empty;
   logic        us_wr_en_o;
   logic [31:0] us_wr_dout_o;
   logic        pf = 1'b0;
   logic        busy_o;
   logic [15:0] frame_cnt_o;
   logic [2:0]  underrun_o;
   logic        missed_start_o;

   int n_tests = 0;
   int n_fail  = 0;

   // bench-side cache FIFOs
   logic [7:0] mem [0:2][0:63];
   int         wcnt [0:2];
   int         rptr [0:2];
   logic [7:0] dout [0:2];
   int         mptr [0:2];
   logic [7:0] nextval = 8'h00;

   logic [31:0] cap_q [$];
   logic [31:0] exp_q [$];
   int          rd1_cnt = 0;

   msg_frame_scheduler #(.CH_NUM(3), .DIN_W(8), .OUT_W(32), .BEATS_PER_CH(8),
                         .SYNC_WORD(16'hEB90), .CH_TAG(8'hC5)) dut (
      .sys_clk_100m(clk), .sw_srst_n(rst_n), .frame_start_pulse_i(start),
      .ch_mask_i(mask), .rd_en_o(rd_en_o), .din_i(din), .empty_i(empty),
      .us_wr_en_o(us_wr_en_o), .us_wr_dout_o(us_wr_dout_o),
      .us_prog_full_i(pf), .busy_o(busy_o), .frame_cnt_o(frame_cnt_o),
      .underrun_o(underrun_o), .missed_start_o(missed_start_o));

   always #5 clk = ~clk;

   // FIFO read port: data valid the cycle after rd_en
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rd_en_o[k]) begin
            dout[k] <= mem[k][rptr[k]];
            rptr[k] <= rptr[k] + 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 3; k++) empty[k] = (rptr[k] >= wcnt[k]);
      din = {dout[2], dout[1], dout[0]};
   end

   // write / read monitors
   always @(negedge clk) begin
      if (us_wr_en_o === 1'b1) cap_q.push_back(us_wr_dout_o);
      if (rd_en_o[1] === 1'b1) rd1_cnt <= rd1_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_bytes(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         mem[k][wcnt[k]] = nextval;
         wcnt[k] = wcnt[k] + 1;
         nextval = nextval + 8'h01;
      end
   endtask

   task automatic build_expected(input logic [15:0] fc, input logic [2:0] m);
      logic [31:0] w;
      logic [31:0] x;
      logic [7:0]  b;
      exp_q.delete();
      w = {16'hEB90, fc};
      exp_q.push_back(w);
      x = w;
      for (int k = 0; k < 3; k++) begin
         if (m[k]) begin
            w = {8'hC5, 8'(k), 16'd8};
            exp_q.push_back(w);
            x = x ^ w;
            for (int wd = 0; wd < 2; wd++) begin
               w = 32'h0;
               for (int bi = 0; bi < 4; bi++) begin
                  if (mptr[k] < wcnt[k]) begin
                     b = mem[k][mptr[k]];
                     mptr[k] = mptr[k] + 1;
                  end else begin
                     b = 8'h00;
                  end
                  w = {w[23:0], b};
               end
               exp_q.push_back(w);
               x = x ^ w;
            end
         end
      end
      exp_q.push_back(x);
   endtask

   task automatic pulse();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n = 0;
      while (busy_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      while (busy_o !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      chk({tag, "_done_in_time"}, 32'(n < 2000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_frame(input string tag, input int base);
      chk({tag, "_word_count"}, 32'(cap_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < cap_q.size())
            chk($sformatf("%s_word%0d", tag, i), cap_q[base + i], exp_q[i]);
      end
   endtask

   initial begin
      int base;
      int stall_wr;
      int stall_rd;
      int rd1_base;
      for (int k = 0; k < 3; k++) begin
         wcnt[k] = 0; mptr[k] = 0;
      end

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rd_en",    32'(rd_en_o), 32'd0);
      chk("rst_wr_en",    32'(us_wr_en_o), 32'd0);
      chk("rst_dout",     us_wr_dout_o, 32'd0);
      chk("rst_busy",     32'(busy_o), 32'd0);
      chk("rst_fcnt",     32'(frame_cnt_o), 32'd0);
      chk("rst_underrun", 32'(underrun_o), 32'd0);
      chk("rst_missed",   32'(missed_start_o), 32'd0);

      // start pulse coincident with reset release is ignored
      mask  = 3'b111;
      rst_n = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_at_release_ignored", 32'(busy_o), 32'd0);

      // frame 1: all channels, bytes 0x00 upward
      for (int k = 0; k < 3; k++) push_bytes(k, 8);
      build_expected(16'd0, 3'b111);
      base = cap_q.size();
      pulse();
      chk("f1_busy_after_start", 32'(busy_o), 32'd1);
      wait_frame("f1");
      chk_frame("f1", base);
      chk("f1_hdr_const",   cap_q[base + 0], 32'hEB90_0000);
      chk("f1_chhdr_const", cap_q[base + 1], 32'hC500_0008);
      chk("f1_data0_const", cap_q[base + 2], 32'h0001_0203);
      chk("f1_fcnt",        32'(frame_cnt_o), 32'd1);
      chk("f1_underrun",    32'(underrun_o), 32'd0);

      // frame 2: mask 101, channel 1 never read
      push_bytes(0, 8); push_bytes(2, 8);
      mask = 3'b101;
      build_expected(16'd1, 3'b101);
      base = cap_q.size();
      rd1_base = rd1_cnt;
      pulse();
      mask = 3'b000;   // mask is latched at start only
      wait_frame("f2");
      chk_frame("f2", base);
      chk("f2_ch2_hdr_const", cap_q[base + 4], 32'hC502_0008);
      chk("f2_rd1_never", 32'(rd1_cnt - rd1_base), 32'd0);
      chk("f2_fcnt", 32'(frame_cnt_o), 32'd2);

      // frame 3: channel 1 holds only 5 bytes
      push_bytes(0, 8); push_bytes(1, 5); push_bytes(2, 8);
      mask = 3'b111;
      build_expected(16'd2, 3'b111);
      base = cap_q.size();
      pulse();
      wait_frame("f3");
      chk_frame("f3", base);
      chk("f3_ch1_word0_const", cap_q[base + 5], 32'h3031_3233);
      chk("f3_ch1_word1_fill",  cap_q[base + 6], 32'h3400_0000);
      chk("f3_underrun", 32'(underrun_o), 32'b010);

      // frame 4: underrun cleared at start, missed start, prog_full stall
      for (int k = 0; k < 3; k++) push_bytes(k, 8);
      build_expected(16'd3, 3'b111);
      base = cap_q.size();
      pulse();
      chk("f4_underrun_cleared", 32'(underrun_o), 32'd0);
      repeat (8) @(negedge clk);
      pulse();
      chk("f4_missed_start", 32'(missed_start_o), 32'd1);
      repeat (4) @(negedge clk);
      pf = 1'b1;
      stall_wr = 0; stall_rd = 0;
      repeat (19) begin
         @(negedge clk);
         if (us_wr_en_o === 1'b1) stall_wr++;
         if (rd_en_o !== 3'b000) stall_rd++;
      end
      @(negedge clk); pf = 1'b0;
      chk("f4_stall_no_wr", 32'(stall_wr), 32'd0);
      chk("f4_stall_no_rd", 32'(stall_rd), 32'd0);
      wait_frame("f4");
      repeat (30) @(negedge clk);
      chk_frame("f4", base);
      chk("f4_fcnt_single", 32'(frame_cnt_o), 32'd4);

      // frame 5 aborted by reset mid-DATA
      for (int k = 0; k < 3; k++) push_bytes(k, 8);
      pulse();
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en",    32'(rd_en_o), 32'd0);
      chk("mid_rst_wr_en",    32'(us_wr_en_o), 32'd0);
      chk("mid_rst_dout",     us_wr_dout_o, 32'd0);
      chk("mid_rst_busy",     32'(busy_o), 32'd0);
      chk("mid_rst_fcnt",     32'(frame_cnt_o), 32'd0);
      chk("mid_rst_missed",   32'(missed_start_o), 32'd0);
      chk("mid_rst_underrun", 32'(underrun_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) push_bytes(k, 8);
      base = cap_q.size();
      pulse();
      wait_frame("f6");
      chk("f6_word_count", 32'(cap_q.size() - base), 32'd11);
      chk("f6_hdr_const",   cap_q[base + 0], 32'hEB90_0000);
      chk("f6_chhdr_const", cap_q[base + 1], 32'hC500_0008);
      chk("f6_fcnt", 32'(frame_cnt_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
